mem_stage: RTL and testbench

Memory-access/writeback stage of the d16 pipeline, directly downstream of the ALU. Consumes the ALU result, store data, register-write request, new SP value and link-register write request. Performs at most one data-memory transaction per instruction over a req/ack bus, stalling upstream while it is outstanding, then issues a single-cycle writeback to the register file, SP and LR.

---
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : d16 memory-access / writeback stage. Runs at most one data-bus
//             transaction per instruction (stalling upstream while it is
//             outstanding), then issues a one-cycle writeback to RF, SP and LR.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mem_op,
  input  logic        byte_op,
  input  logic [15:0] out,
  input  logic [15:0] mem_data,
  input  logic        write,
  input  logic [2:0]  rD_sel,
  input  logic        sp_wr,
  input  logic [15:0] SP_out,
  input  logic        lr_wr_en,
  input  logic [15:0] lr_data,
  output logic        stall,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_sel,
  output logic [15:0] rf_wr_data,
  output logic        sp_wr_en,
  output logic [15:0] sp_data,
  output logic        lr_we,
  output logic [15:0] lr_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic [1:0]  bus_be,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] C_OP_LOAD  = 2'b01;
  localparam logic [1:0] C_OP_STORE = 2'b10;

  state_t      state_q, state_d;
  logic        take_alu_d, take_mem_d, done_d;
  logic [15:0] load_data_d;

  // Instruction fields held across the bus transaction
  logic        is_load_q, byte_q, write_q, sp_wr_q, lr_wr_q;
  logic [2:0]  sel_q;
  logic [15:0] out_q, sp_q, lr_q;

  // Registered outputs
  logic        rf_wr_en_q, sp_wr_en_q, lr_we_q, bus_req_q, bus_we_q;
  logic [2:0]  rf_wr_sel_q;
  logic [15:0] rf_wr_data_q, sp_data_q, lr_wdata_q, bus_addr_q, bus_wdata_q;
  logic [1:0]  bus_be_q;

  // Next-state decode: which instruction is accepted and when the bus completes
  always_comb begin
    state_d    = state_q;
    take_alu_d = 1'b0;
    take_mem_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (mem_op == C_OP_LOAD || mem_op == C_OP_STORE) begin
            take_mem_d = 1'b1;
            state_d    = S_ACCESS;
          end else begin
            take_alu_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (bus_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte loads pick the lane selected by the low address bit, zero-extended
  always_comb begin
    load_data_d = bus_rdata;
    if (byte_q) begin
      load_data_d = out_q[0] ? {8'h00, bus_rdata[15:8]} : {8'h00, bus_rdata[7:0]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latch instruction, drive bus, produce one-cycle writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_q    <= 1'b0;
      byte_q       <= 1'b0;
      write_q      <= 1'b0;
      sp_wr_q      <= 1'b0;
      lr_wr_q      <= 1'b0;
      sel_q        <= 3'd0;
      out_q        <= 16'd0;
      sp_q         <= 16'd0;
      lr_q         <= 16'd0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_sel_q  <= 3'd0;
      rf_wr_data_q <= 16'd0;
      sp_wr_en_q   <= 1'b0;
      sp_data_q    <= 16'd0;
      lr_we_q      <= 1'b0;
      lr_wdata_q   <= 16'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 16'd0;
      bus_wdata_q  <= 16'd0;
      bus_be_q     <= 2'b00;
    end else begin
      rf_wr_en_q <= 1'b0;
      sp_wr_en_q <= 1'b0;
      lr_we_q    <= 1'b0;

      if (take_alu_d) begin
        rf_wr_en_q   <= write;
        rf_wr_sel_q  <= rD_sel;
        rf_wr_data_q <= out;
        sp_wr_en_q   <= sp_wr;
        sp_data_q    <= SP_out;
        lr_we_q      <= lr_wr_en;
        lr_wdata_q   <= lr_data;
      end

      if (take_mem_d) begin
        is_load_q   <= (mem_op == C_OP_LOAD);
        byte_q      <= byte_op;
        write_q     <= write;
        sp_wr_q     <= sp_wr;
        lr_wr_q     <= lr_wr_en;
        sel_q       <= rD_sel;
        out_q       <= out;
        sp_q        <= SP_out;
        lr_q        <= lr_data;
        bus_req_q   <= 1'b1;
        bus_we_q    <= (mem_op == C_OP_STORE);
        bus_addr_q  <= byte_op ? out : {out[15:1], 1'b0};
        bus_wdata_q <= byte_op ? {mem_data[7:0], mem_data[7:0]} : mem_data;
        bus_be_q    <= byte_op ? (out[0] ? 2'b10 : 2'b01) : 2'b11;
      end

      if (done_d) begin
        bus_req_q    <= 1'b0;
        rf_wr_en_q   <= write_q;
        rf_wr_sel_q  <= sel_q;
        rf_wr_data_q <= is_load_q ? load_data_d : out_q;
        sp_wr_en_q   <= sp_wr_q;
        sp_data_q    <= sp_q;
        lr_we_q      <= lr_wr_q;
        lr_wdata_q   <= lr_q;
      end
    end
  end

  assign stall      = (state_q == S_ACCESS);
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_sel  = rf_wr_sel_q;
  assign rf_wr_data = rf_wr_data_q;
  assign sp_wr_en   = sp_wr_en_q;
  assign sp_data    = sp_data_q;
  assign lr_we      = lr_we_q;
  assign lr_wdata   = lr_wdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: transaction-level reference
//             model compared every cycle, plus directed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, en, byte_op, write, sp_wr, lr_wr_en, bus_ack;
  logic [1:0]  mem_op;
  logic [2:0]  rD_sel;
  logic [15:0] out, mem_data, SP_out, lr_data, bus_rdata;
  logic        stall, rf_wr_en, sp_wr_en, lr_we, bus_req, bus_we;
  logic [2:0]  rf_wr_sel;
  logic [15:0] rf_wr_data, sp_data, lr_wdata, bus_addr, bus_wdata;
  logic [1:0]  bus_be;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .en(en), .mem_op(mem_op), .byte_op(byte_op),
    .out(out), .mem_data(mem_data), .write(write), .rD_sel(rD_sel),
    .sp_wr(sp_wr), .SP_out(SP_out), .lr_wr_en(lr_wr_en), .lr_data(lr_data),
    .stall(stall), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .rf_wr_data(rf_wr_data), .sp_wr_en(sp_wr_en), .sp_data(sp_data),
    .lr_we(lr_we), .lr_wdata(lr_wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-level view) ----------------
  bit          m_busy;
  int          m_op;
  bit          m_byte, m_write, m_spw, m_lrw;
  int          m_sel;
  int          m_out, m_sp, m_lr;
  bit          e_req, e_we, e_rf, e_spe, e_lre;
  int          e_addr, e_wdata, e_be, e_sel, e_rfd, e_spd, e_lrd;
  int          n_accepted = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; e_req <= 1'b0; e_rf <= 1'b0; e_spe <= 1'b0; e_lre <= 1'b0;
    end else begin
      e_rf <= 1'b0; e_spe <= 1'b0; e_lre <= 1'b0;
      if (!m_busy && en) begin
        n_accepted <= n_accepted + 1;
        if (mem_op == 2'd1 || mem_op == 2'd2) begin
          m_busy  <= 1'b1;
          m_op    <= int'(mem_op);
          m_byte  <= byte_op; m_write <= write; m_spw <= sp_wr; m_lrw <= lr_wr_en;
          m_sel   <= int'(rD_sel); m_out <= int'(out); m_sp <= int'(SP_out); m_lr <= int'(lr_data);
          e_req   <= 1'b1;
          e_we    <= (mem_op == 2'd2);
          e_addr  <= byte_op ? int'(out) : int'(out) - (int'(out) % 2);
          e_be    <= !byte_op ? 3 : ((int'(out) % 2 == 1) ? 2 : 1);
          e_wdata <= byte_op ? (int'(mem_data) % 256) * 257 : int'(mem_data);
        end else begin
          e_rf <= write; e_sel <= int'(rD_sel); e_rfd <= int'(out);
          e_spe <= sp_wr; e_spd <= int'(SP_out);
          e_lre <= lr_wr_en; e_lrd <= int'(lr_data);
        end
      end else if (m_busy && bus_ack) begin
        m_busy <= 1'b0;
        e_req  <= 1'b0;
        e_rf   <= m_write; e_sel <= m_sel;
        if (m_op == 1)
          e_rfd <= m_byte ? (int'(bus_rdata) / ((m_out % 2 == 1) ? 256 : 1)) % 256 : int'(bus_rdata);
        else
          e_rfd <= m_out;
        e_spe <= m_spw; e_spd <= m_sp;
        e_lre <= m_lrw; e_lrd <= m_lr;
      end
    end
  end

  // Single compare process against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_stall", 32'(stall), 32'(m_busy));
      chk("m_bus_req", 32'(bus_req), 32'(e_req));
      if (e_req) begin
        chk("m_bus_we", 32'(bus_we), 32'(e_we));
        chk("m_bus_addr", 32'(bus_addr), e_addr);
        chk("m_bus_wdata", 32'(bus_wdata), e_wdata);
        chk("m_bus_be", 32'(bus_be), e_be);
      end
      chk("m_rf_wr_en", 32'(rf_wr_en), 32'(e_rf));
      if (e_rf) begin
        chk("m_rf_wr_sel", 32'(rf_wr_sel), e_sel);
        chk("m_rf_wr_data", 32'(rf_wr_data), e_rfd);
      end
      chk("m_sp_wr_en", 32'(sp_wr_en), 32'(e_spe));
      if (e_spe) chk("m_sp_data", 32'(sp_data), e_spd);
      chk("m_lr_we", 32'(lr_we), 32'(e_lre));
      if (e_lre) chk("m_lr_wdata", 32'(lr_wdata), e_lrd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] op, input logic b, input logic [15:0] o,
                        input logic [15:0] md, input logic w, input logic [2:0] sel,
                        input logic spw, input logic [15:0] sp,
                        input logic lrw, input logic [15:0] lrd);
    en = 1'b1; mem_op = op; byte_op = b; out = o; mem_data = md; write = w;
    rD_sel = sel; sp_wr = spw; SP_out = sp; lr_wr_en = lrw; lr_data = lrd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero_ctl"}, {26'd0, stall, rf_wr_en, sp_wr_en, lr_we, bus_req, bus_we}, 32'd0);
    chk({tag, "_zero_rf"}, {13'd0, rf_wr_sel, rf_wr_data}, 32'd0);
    chk({tag, "_zero_splr"}, {sp_data, lr_wdata}, 32'd0);
    chk({tag, "_zero_bus"}, {bus_addr, bus_wdata}, 32'd0);
    chk({tag, "_zero_be"}, 32'(bus_be), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mem_op = 2'd0; byte_op = 1'b0; out = 16'd0; mem_data = 16'd0;
    write = 1'b0; rD_sel = 3'd0; sp_wr = 1'b0; SP_out = 16'd0; lr_wr_en = 1'b0;
    lr_data = 16'd0; bus_ack = 1'b0; bus_rdata = 16'd0;
    step(); step(); step();
    @(negedge clk);
    chk_all_zero("reset");
    chk_on = 1'b1;
    rst = 1'b0;

    // ALU op: writeback next cycle, one-cycle pulse
    step();
    set_op(2'd0, 1'b0, 16'h0007, 16'h0000, 1'b1, 3'd3, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("alu_rf_en", 32'(rf_wr_en), 32'd1);
    chk("alu_rf_sel", 32'(rf_wr_sel), 32'd3);
    chk("alu_rf_data", 32'(rf_wr_data), 32'h0007);
    chk("alu_stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    chk("alu_pulse_end", 32'(rf_wr_en), 32'd0);

    // Word load, ack after three stall cycles
    set_op(2'd1, 1'b0, 16'h0101, 16'h0000, 1'b1, 3'd4, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wl_stall", 32'(stall), 32'd1);
      if (i == 0) begin
        chk("wl_addr", 32'(bus_addr), 32'h0100);
        chk("wl_be", 32'(bus_be), 32'd3);
      end
      if (i == 2) begin bus_ack = 1'b1; bus_rdata = 16'hBEEF; end
    end
    step(); bus_ack = 1'b0;
    @(negedge clk);
    chk("wl_rf_en", 32'(rf_wr_en), 32'd1);
    chk("wl_rf_data", 32'(rf_wr_data), 32'hBEEF);
    chk("wl_req_drop", 32'({bus_req, stall}), 32'd0);
    step();
    @(negedge clk);
    chk("wl_pulse_end", 32'(rf_wr_en), 32'd0);

    // Push: zero-wait store with SP update
    set_op(2'd2, 1'b0, 16'h00FE, 16'h0567, 1'b0, 3'd0, 1'b1, 16'h00FE, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("push_we", 32'(bus_we), 32'd1);
    chk("push_addr", 32'(bus_addr), 32'h00FE);
    chk("push_wdata", 32'(bus_wdata), 32'h0567);
    bus_ack = 1'b1;
    step(); bus_ack = 1'b0;
    @(negedge clk);
    chk("push_sp_en", 32'(sp_wr_en), 32'd1);
    chk("push_sp_data", 32'(sp_data), 32'h00FE);
    chk("push_rf_en", 32'(rf_wr_en), 32'd0);

    // Byte load at odd and even addresses
    set_op(2'd1, 1'b1, 16'h0203, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("bl_odd_be", 32'(bus_be), 32'd2);
    chk("bl_odd_addr", 32'(bus_addr), 32'h0203);
    bus_ack = 1'b1; bus_rdata = 16'hA55A;
    step(); bus_ack = 1'b0;
    @(negedge clk);
    chk("bl_odd_data", 32'(rf_wr_data), 32'h00A5);
    set_op(2'd1, 1'b1, 16'h0204, 16'h0000, 1'b1, 3'd6, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("bl_even_be", 32'(bus_be), 32'd1);
    bus_ack = 1'b1;
    step(); bus_ack = 1'b0;
    @(negedge clk);
    chk("bl_even_data", 32'(rf_wr_data), 32'h005A);

    // Byte store replicates the low byte
    set_op(2'd2, 1'b1, 16'h0011, 16'h12AB, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("bs_wdata", 32'(bus_wdata), 32'hABAB);
    chk("bs_be", 32'(bus_be), 32'd2);
    bus_ack = 1'b1;
    step(); bus_ack = 1'b0;

    // mem_op 11 behaves as a plain op; LR write
    set_op(2'd3, 1'b0, 16'h0099, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'hABCD);
    step(); en = 1'b0;
    @(negedge clk);
    chk("op11_lr_we", 32'(lr_we), 32'd1);
    chk("op11_lr_data", 32'(lr_wdata), 32'hABCD);
    chk("op11_no_bus", 32'({bus_req, stall}), 32'd0);

    // Reset mid-ACCESS with ack in the same cycle
    set_op(2'd1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h1234, 1'b1, 16'h5678);
    step(); en = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 16'hFFFF; rst = 1'b1;
    step(); bus_ack = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    step();
    @(negedge clk);
    chk("rst_no_wb", 32'({rf_wr_en, sp_wr_en, lr_we}), 32'd0);
    set_op(2'd0, 1'b0, 16'h0033, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(); en = 1'b0;
    @(negedge clk);
    chk("post_rst_rf_data", 32'({rf_wr_en, rf_wr_data}), 32'h10033);

    // en held high while stalled: second op taken only after ack
    set_op(2'd1, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    set_op(2'd0, 1'b0, 16'h0042, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("hold_stall", 32'(stall), 32'd1);
    bus_ack = 1'b1; bus_rdata = 16'h1234;
    step(); bus_ack = 1'b0;
    @(negedge clk);
    chk("hold_ld_wb", 32'({rf_wr_en, rf_wr_sel, rf_wr_data}), {12'd0, 1'b1, 3'd1, 16'h1234});
    step(); en = 1'b0;
    @(negedge clk);
    chk("hold_alu_wb", 32'({rf_wr_en, rf_wr_sel, rf_wr_data}), {12'd0, 1'b1, 3'd2, 16'h0042});
    step();
    @(negedge clk);
    chk("hold_single_wb", 32'(rf_wr_en), 32'd0);

    // Back-to-back stores: bus_req low for exactly one cycle between them
    set_op(2'd2, 1'b0, 16'h0020, 16'h1111, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    set_op(2'd2, 1'b0, 16'h0030, 16'h2222, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    bus_ack = 1'b1;
    step();
    @(negedge clk);
    chk("b2b_gap", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    step(); en = 1'b0;
    @(negedge clk);
    chk("b2b_second", 32'({bus_req, bus_addr}), 32'h10030);
    bus_ack = 1'b1;
    step(); bus_ack = 1'b0;

    // Random traffic checked by the model only
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 9) < 7);
      mem_op = 2'($urandom_range(0, 3));
      byte_op = 1'($urandom_range(0, 1));
      out = 16'($urandom); mem_data = 16'($urandom);
      write = 1'($urandom_range(0, 1)); rD_sel = 3'($urandom_range(0, 7));
      sp_wr = 1'($urandom_range(0, 1)); SP_out = 16'($urandom);
      lr_wr_en = 1'($urandom_range(0, 1)); lr_data = 16'($urandom);
      bus_ack = ($urandom_range(0, 2) == 0); bus_rdata = 16'($urandom);
      step();
    end
    en = 1'b0; bus_ack = 1'b1;
    step(); step(); step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
